// File: rtl/neg_accum.sv
`default_nettype none
// ============================================================================
// Module   : neg_accum
// Summary  : Block accumulator for signed 4-bit samples with a valid/ready
//            handshake on both sides and a sticky signed-overflow flag.
//            Define NEG_ACCUM_SAT_EN to saturate on overflow instead of
//            wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module neg_accum #(
    parameter int ACC_W     = 8,
    parameter int BLOCK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [3:0]       din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic [2:0]       cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    localparam logic [0:0] c_st_acc = 1'b0;
    localparam logic [0:0] c_st_out = 1'b1;

    // The final accept is detected one count early so BLOCK_LEN=8 fits in 3 bits.
    localparam logic [2:0] c_last_idx = 3'(BLOCK_LEN - 1);

    localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [2:0]       r_cnt;
    logic             r_ovf;

    logic [0:0]       w_state_nxt;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [2:0]       w_cnt_nxt;
    logic             w_ovf_nxt;

    logic             w_accept;
    logic [ACC_W:0]   w_din_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_add_ovf;
    logic [ACC_W-1:0] w_acc_add;

    // One guard bit: the sum is exact in ACC_W+1 bits, so overflow is a sign mismatch.
    assign w_din_ext = {{(ACC_W-3){din[3]}}, din};
    assign w_sum     = {r_acc[ACC_W-1], r_acc} + w_din_ext;
    assign w_add_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_accept  = in_valid && (r_state == c_st_acc) && !clr;

    always_comb begin
        w_acc_add = w_sum[ACC_W-1:0];
`ifdef NEG_ACCUM_SAT_EN
        if (w_add_ovf) begin
            w_acc_add = w_sum[ACC_W] ? c_acc_min : c_acc_max;
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_state_nxt = c_st_acc;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                c_st_acc: begin
                    if (w_accept) begin
                        w_acc_nxt = w_acc_add;
                        w_cnt_nxt = r_cnt + 3'd1;
                        w_ovf_nxt = r_ovf | w_add_ovf;
                        if (r_cnt == c_last_idx) begin
                            w_state_nxt = c_st_out;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        w_state_nxt = c_st_acc;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_acc;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign in_ready  = (r_state == c_st_acc);
    assign out_valid = (r_state == c_st_out);
    assign acc       = r_acc;
    assign cnt       = r_cnt;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/neg_accum.md
NEG_ACCUM -- requirements
Module: neg_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 8: accumulator width in bits, legal range 5..16.
REQ-002 SHALL have parameter BLOCK_LEN, default 4: samples summed per block, legal range 2..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port clr, input, 1 bit: synchronous block restart.
REQ-006 SHALL have port din, input, 4 bits: two's-complement sample from the upstream negation stage.
REQ-007 SHALL have port in_valid, input, 1 bit: din is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts din this cycle.
REQ-009 SHALL have port acc, output, ACC_W bits: signed running or final block sum.
REQ-010 SHALL have port cnt, output, 3 bits: samples accepted in the current block.
REQ-011 SHALL have port out_valid, output, 1 bit: acc holds a completed block sum.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes the block sum.
REQ-013 SHALL have port ovf, output, 1 bit: sticky signed-overflow flag for the current block.

Function
REQ-014 SHALL implement a two-state FSM with states ACC and OUT.
REQ-015 In ACC: in_ready=1 and out_valid=0.
REQ-016 In OUT: in_ready=0, out_valid=1, and acc, cnt and ovf held stable.
REQ-017 An accept (in_valid & in_ready) SHALL update acc to acc + sign_extend(din, ACC_W) and increment cnt.
REQ-018 An accept that makes cnt equal BLOCK_LEN SHALL move the FSM to OUT, with out_valid high the next cycle (latency 1 cycle after the final accept).
REQ-019 In OUT with out_ready=1, the next cycle SHALL be ACC with acc=0, cnt=0, ovf=0.
REQ-020 In OUT, in_valid SHALL be ignored, including when it coincides with out_ready; no sample is accepted in the transition cycle.
REQ-021 In OUT with out_ready=0, the FSM SHALL stay in OUT indefinitely with outputs unchanged.
REQ-022 ovf SHALL set when an accepted add produces a signed result outside the ACC_W range, and SHALL stay set until the block is consumed, clr, or rst.
REQ-023 clr SHALL take priority over all events in any state: next cycle is ACC with acc=0, cnt=0, ovf=0; a sample presented in the same cycle is dropped.
REQ-024 Mid-block, the intermediate acc value SHALL be visible on acc while out_valid=0.

Reset
REQ-025 On rst=1, the block SHALL immediately enter ACC with acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1, regardless of state, including mid-block or in OUT.
REQ-026 After rst deasserts, the block SHALL accept a sample on the first rising edge.

Configuration
REQ-027 With macro NEG_ACCUM_SAT_EN defined: an overflowing add SHALL clamp acc to 2^(ACC_W-1)-1 or -2^(ACC_W-1), and ovf SHALL still set.
REQ-028 With NEG_ACCUM_SAT_EN undefined: an overflowing add SHALL wrap modulo 2^ACC_W, and ovf SHALL set.

Verification
REQ-029 Reset: assert rst asynchronously mid-cycle -> acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1 without waiting for a clock edge.
REQ-030 Basic block (ACC_W=8, BLOCK_LEN=4): din 0x1,0xF,0x7,0x8 on consecutive cycles -> acc=0xFF, ovf=0, out_valid=1 one cycle after the 4th accept.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in OUT with in_valid=1 -> acc/cnt stable, in_ready=0; out_ready=1 -> next cycle acc=0, cnt=0.
REQ-032 Overflow (ACC_W=5, BLOCK_LEN=4): din 0x7 x4 -> acc=0x1C and ovf=1 without NEG_ACCUM_SAT_EN; acc=0x0F and ovf=1 with it.
REQ-033 clr mid-block: accept 0x3,0x2, then clr with in_valid=1 and din=0x5 -> acc=0, cnt=0; the next four samples form a complete new block.
REQ-034 rst while in OUT with out_ready=0 -> out_valid drops immediately and acc=0.
